// File: rtl/riscv_pkg.sv
// Shared fetch-stage types and constants: data/address width, instruction width,
// sequential PC increment and the fetch FSM state encoding.
package riscv_pkg;

  localparam int XLEN    = 32;
  localparam int INSTR_W = 32;
  localparam int PC_STEP = 4;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    HOLD = 3'd3,
    ERR  = 3'd4
  } fetch_state_t;

  // A fetch target is misaligned when either of its two low bits is set.
  function automatic logic is_misaligned(input logic [1:0] low_bits);
    return |low_bits;
  endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Fetch-stage bus: execute redirect, instruction-memory request/response and
// the decode handshake. master = fetch unit, slave = its environment.
interface pc_fetch_unit_if #(
  parameter int XLEN = 32
);

  logic            redirect_valid;
  logic [XLEN-1:0] redirect_target;
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_resp_valid;
  logic [31:0]     imem_resp_data;
  logic            if_valid;
  logic            if_ready;
  logic [XLEN-1:0] if_pc;
  logic [31:0]     if_instr;
  logic            misalign_err;

  modport master (
    input  redirect_valid, redirect_target, imem_req_ready,
    input  imem_resp_valid, imem_resp_data, if_ready,
    output imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr, misalign_err
  );

  modport slave (
    output redirect_valid, redirect_target, imem_req_ready,
    output imem_resp_valid, imem_resp_data, if_ready,
    input  imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr, misalign_err
  );

endinterface

// File: rtl/mux2_1.sv
// Generic 2:1 word multiplexer: y = s ? b : a.
module mux2_1 #(
  parameter int W = 32
) (
  input  logic         s,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);

  assign y = s ? b : a;

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: one outstanding imem request, redirect flush, decode handoff.
// Optional misaligned-redirect trap enabled by defining PC_MISALIGN_TRAP_EN.
module pc_fetch_unit
  import riscv_pkg::*;
#(
  parameter int              XLEN         = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             reset,
  pc_fetch_unit_if.master  bus
);

  fetch_state_t           state_r;
  logic [XLEN-1:0]        pc_r;
  logic [INSTR_W-1:0]     hold_r;
  logic                   drop_r;
  logic [XLEN-1:0]        pc_plus4_s;
  logic [XLEN-1:0]        target_s;
  logic [XLEN-1:0]        next_pc_s;
  logic                   trap_s;

`ifdef PC_MISALIGN_TRAP_EN
  logic                   misalign_r;

  assign target_s = bus.redirect_target;
  assign trap_s   = bus.redirect_valid && is_misaligned(bus.redirect_target[1:0]);
  assign bus.misalign_err = misalign_r;
`else
  // Low bits are cleared so a misaligned redirect fetches the enclosing word.
  assign target_s = bus.redirect_target & ~{{(XLEN-2){1'b0}}, 2'b11};
  assign trap_s   = 1'b0;
  assign bus.misalign_err = 1'b0;
`endif

  assign pc_plus4_s = pc_r + XLEN'(PC_STEP);

  mux2_1 #(.W(XLEN)) u_next_pc_mux (
    .s (bus.redirect_valid),
    .a (pc_plus4_s),
    .b (target_s),
    .y (next_pc_s)
  );

  // Fetch FSM: PC, drop-pending flag and held instruction word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= IDLE;
      pc_r       <= RESET_VECTOR;
      drop_r     <= 1'b0;
      hold_r     <= '0;
`ifdef PC_MISALIGN_TRAP_EN
      misalign_r <= 1'b0;
`endif
    end else begin
`ifdef PC_MISALIGN_TRAP_EN
      misalign_r <= 1'b0;
`endif
      if (trap_s && (state_r != ERR)) begin
        state_r    <= ERR;
        drop_r     <= 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
        misalign_r <= 1'b1;
`endif
      end else begin
        case (state_r)
          IDLE: begin
            if (bus.redirect_valid) begin
              pc_r <= next_pc_s;
            end
            state_r <= REQ;
          end
          REQ: begin
            if (bus.redirect_valid) begin
              pc_r <= next_pc_s;
              // An accepted request to the old address still returns a word.
              if (bus.imem_req_ready) begin
                drop_r  <= 1'b1;
                state_r <= WAIT;
              end else begin
                state_r <= REQ;
              end
            end else if (bus.imem_req_ready) begin
              state_r <= WAIT;
            end else begin
              state_r <= REQ;
            end
          end
          WAIT: begin
            if (bus.redirect_valid) begin
              pc_r <= next_pc_s;
              if (bus.imem_resp_valid) begin
                drop_r  <= 1'b0;
                state_r <= REQ;
              end else begin
                drop_r  <= 1'b1;
                state_r <= WAIT;
              end
            end else if (bus.imem_resp_valid) begin
              if (drop_r) begin
                drop_r  <= 1'b0;
                state_r <= REQ;
              end else begin
                hold_r  <= bus.imem_resp_data;
                state_r <= HOLD;
              end
            end else begin
              state_r <= WAIT;
            end
          end
          HOLD: begin
            if (bus.redirect_valid || bus.if_ready) begin
              pc_r    <= next_pc_s;
              state_r <= REQ;
            end else begin
              state_r <= HOLD;
            end
          end
          ERR: begin
            state_r <= ERR;
          end
          default: begin
            state_r <= IDLE;
            drop_r  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.imem_req_valid = (state_r == REQ);
  assign bus.imem_req_addr  = (state_r == REQ)  ? pc_r   : '0;
  assign bus.if_valid       = (state_r == HOLD);
  assign bus.if_pc          = (state_r == HOLD) ? pc_r   : '0;
  assign bus.if_instr       = (state_r == HOLD) ? hold_r : '0;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: sequential fetch, decode stall, redirects,
// PC wrap-around, async reset mid-transaction and misaligned redirect (PC_MISALIGN_TRAP_EN).
module tb_pc_fetch_unit;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  pc_fetch_unit_if #(.XLEN(32)) bus_a ();
  pc_fetch_unit_if #(.XLEN(32)) bus_b ();

  pc_fetch_unit #(.XLEN(32), .RESET_VECTOR(32'h0000_0000)) u_dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a.master)
  );

  pc_fetch_unit #(.XLEN(32), .RESET_VECTOR(32'hFFFF_FFFC)) u_dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Entered with DUT A in REQ; walks one instruction through WAIT and HOLD.
  task automatic fetch(input string tag, input logic [31:0] addr, input logic [31:0] word,
                       input int stall);
    chk({tag, "_req_valid"}, 32'(bus_a.imem_req_valid), 32'd1);
    chk({tag, "_req_addr"}, bus_a.imem_req_addr, addr);
    bus_a.imem_req_ready = 1'b1;
    step();
    bus_a.imem_req_ready = 1'b0;
    chk({tag, "_wait_req_valid"}, 32'(bus_a.imem_req_valid), 32'd0);
    bus_a.imem_resp_valid = 1'b1;
    bus_a.imem_resp_data  = word;
    step();
    bus_a.imem_resp_valid = 1'b0;
    bus_a.imem_resp_data  = 32'h0;
    for (int i = 0; i < stall; i++) begin
      chk({tag, "_stall_if_valid"}, 32'(bus_a.if_valid), 32'd1);
      chk({tag, "_stall_if_pc"}, bus_a.if_pc, addr);
      chk({tag, "_stall_if_instr"}, bus_a.if_instr, word);
      chk({tag, "_stall_no_req"}, 32'(bus_a.imem_req_valid), 32'd0);
      step();
    end
    chk({tag, "_if_valid"}, 32'(bus_a.if_valid), 32'd1);
    chk({tag, "_if_pc"}, bus_a.if_pc, addr);
    chk({tag, "_if_instr"}, bus_a.if_instr, word);
    bus_a.if_ready = 1'b1;
    step();
    bus_a.if_ready = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b0;
    bus_a.redirect_valid  = 1'b0;
    bus_a.redirect_target = 32'h0;
    bus_a.imem_req_ready  = 1'b0;
    bus_a.imem_resp_valid = 1'b0;
    bus_a.imem_resp_data  = 32'h0;
    bus_a.if_ready        = 1'b0;
    bus_b.redirect_valid  = 1'b0;
    bus_b.redirect_target = 32'h0;
    bus_b.imem_req_ready  = 1'b0;
    bus_b.imem_resp_valid = 1'b0;
    bus_b.imem_resp_data  = 32'h0;
    bus_b.if_ready        = 1'b0;

    #1;
    chk("rst_req_valid", 32'(bus_a.imem_req_valid), 32'd0);
    chk("rst_req_addr", bus_a.imem_req_addr, 32'h0);
    chk("rst_if_valid", 32'(bus_a.if_valid), 32'd0);
    chk("rst_if_pc", bus_a.if_pc, 32'h0);
    chk("rst_misalign", 32'(bus_a.misalign_err), 32'd0);
    chk("rst_b_req_addr", bus_b.imem_req_addr, 32'h0);
    step();
    step();
    reset = 1'b1;
    step();

    // PC wrap on the DUT whose reset vector is the last word of the space.
    chk("b_req_valid", 32'(bus_b.imem_req_valid), 32'd1);
    chk("b_first_addr", bus_b.imem_req_addr, 32'hFFFF_FFFC);
    bus_b.imem_req_ready = 1'b1;
    step();
    bus_b.imem_req_ready  = 1'b0;
    bus_b.imem_resp_valid = 1'b1;
    bus_b.imem_resp_data  = 32'hA5A5_0001;
    step();
    bus_b.imem_resp_valid = 1'b0;
    chk("b_if_pc", bus_b.if_pc, 32'hFFFF_FFFC);
    chk("b_if_instr", bus_b.if_instr, 32'hA5A5_0001);
    bus_b.if_ready = 1'b1;
    step();
    bus_b.if_ready = 1'b0;
    chk("b_wrap_addr", bus_b.imem_req_addr, 32'h0000_0000);
    chk("b_wrap_req_valid", 32'(bus_b.imem_req_valid), 32'd1);

    // Async reset while A sits in REQ; a response during/after reset is ignored.
    chk("a_pre_rst_req_valid", 32'(bus_a.imem_req_valid), 32'd1);
    reset = 1'b0;
    bus_a.imem_resp_valid = 1'b1;
    bus_a.imem_resp_data  = 32'hBAD0_0000;
    #1;
    chk("async_rst_req_valid", 32'(bus_a.imem_req_valid), 32'd0);
    chk("async_rst_if_valid", 32'(bus_a.if_valid), 32'd0);
    step();
    reset = 1'b1;
    step();
    bus_a.imem_resp_valid = 1'b0;
    chk("post_rst_if_valid", 32'(bus_a.if_valid), 32'd0);

    fetch("seq0", 32'h0000_0000, 32'h0000_0013, 0);
    fetch("seq1", 32'h0000_0004, 32'h0010_0093, 0);
    fetch("seq2", 32'h0000_0008, 32'h0020_0113, 0);
    fetch("stall", 32'h0000_000C, 32'h1234_5678, 5);

    // Redirect in WAIT with a same-cycle response: response dropped.
    chk("wr_req_addr", bus_a.imem_req_addr, 32'h0000_0010);
    bus_a.imem_req_ready = 1'b1;
    step();
    bus_a.imem_req_ready  = 1'b0;
    bus_a.redirect_valid  = 1'b1;
    bus_a.redirect_target = 32'h0000_0100;
    bus_a.imem_resp_valid = 1'b1;
    bus_a.imem_resp_data  = 32'hDEAD_BEEF;
    step();
    bus_a.redirect_valid  = 1'b0;
    bus_a.imem_resp_valid = 1'b0;
    chk("wr_if_valid", 32'(bus_a.if_valid), 32'd0);
    chk("wr_next_addr", bus_a.imem_req_addr, 32'h0000_0100);

    // Redirect in WAIT, stale response a cycle later: dropped.
    bus_a.imem_req_ready = 1'b1;
    step();
    bus_a.imem_req_ready  = 1'b0;
    bus_a.redirect_valid  = 1'b1;
    bus_a.redirect_target = 32'h0000_0180;
    step();
    bus_a.redirect_valid = 1'b0;
    chk("wl_still_wait", 32'(bus_a.imem_req_valid), 32'd0);
    bus_a.imem_resp_valid = 1'b1;
    bus_a.imem_resp_data  = 32'hDEAD_0100;
    step();
    bus_a.imem_resp_valid = 1'b0;
    chk("wl_if_valid", 32'(bus_a.if_valid), 32'd0);
    fetch("after_wl", 32'h0000_0180, 32'hCAFE_0180, 0);

    // Redirect in HOLD with same-cycle if_ready.
    bus_a.imem_req_ready = 1'b1;
    step();
    bus_a.imem_req_ready  = 1'b0;
    bus_a.imem_resp_valid = 1'b1;
    bus_a.imem_resp_data  = 32'hCAFE_0184;
    step();
    bus_a.imem_resp_valid = 1'b0;
    chk("hr_if_pc", bus_a.if_pc, 32'h0000_0184);
    bus_a.redirect_valid  = 1'b1;
    bus_a.redirect_target = 32'h0000_0200;
    bus_a.if_ready        = 1'b1;
    step();
    bus_a.redirect_valid = 1'b0;
    bus_a.if_ready       = 1'b0;
    chk("hr_if_valid", 32'(bus_a.if_valid), 32'd0);
    chk("hr_next_addr", bus_a.imem_req_addr, 32'h0000_0200);

    // Redirect in REQ while the old request is accepted.
    bus_a.redirect_valid  = 1'b1;
    bus_a.redirect_target = 32'h0000_0300;
    bus_a.imem_req_ready  = 1'b1;
    step();
    bus_a.redirect_valid = 1'b0;
    bus_a.imem_req_ready = 1'b0;
    chk("rr_wait_req_valid", 32'(bus_a.imem_req_valid), 32'd0);
    bus_a.imem_resp_valid = 1'b1;
    bus_a.imem_resp_data  = 32'hDEAD_0200;
    step();
    bus_a.imem_resp_valid = 1'b0;
    chk("rr_if_valid", 32'(bus_a.if_valid), 32'd0);
    fetch("after_rr", 32'h0000_0300, 32'hCAFE_0300, 0);

    // Response outside WAIT is ignored.
    bus_a.imem_resp_valid = 1'b1;
    bus_a.imem_resp_data  = 32'hDEAD_0304;
    step();
    bus_a.imem_resp_valid = 1'b0;
    chk("stray_if_valid", 32'(bus_a.if_valid), 32'd0);
    chk("stray_req_addr", bus_a.imem_req_addr, 32'h0000_0304);

    // Misaligned redirect.
    bus_a.redirect_valid  = 1'b1;
    bus_a.redirect_target = 32'h0000_0102;
    step();
    bus_a.redirect_valid = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
    chk("mis_err_pulse", 32'(bus_a.misalign_err), 32'd1);
    chk("mis_no_req", 32'(bus_a.imem_req_valid), 32'd0);
    bus_a.imem_req_ready = 1'b1;
    step();
    chk("mis_err_clear", 32'(bus_a.misalign_err), 32'd0);
    chk("mis_err_no_req", 32'(bus_a.imem_req_valid), 32'd0);
    step();
    bus_a.imem_req_ready = 1'b0;
    chk("mis_err_stuck", 32'(bus_a.imem_req_valid), 32'd0);
    chk("mis_err_if_valid", 32'(bus_a.if_valid), 32'd0);
`else
    chk("mis_err_tied", 32'(bus_a.misalign_err), 32'd0);
    fetch("mis_align", 32'h0000_0100, 32'hCAFE_0100, 0);
    chk("mis_next_addr", bus_a.imem_req_addr, 32'h0000_0104);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
